id_ex_alu_feed: RTL and testbench

- ID/EX pipeline stage that sits directly upstream of the 32-bit ALU and drives its op1, op2 and 3-bit sel inputs.
- Registers decoded-instruction fields from ID and translates aluop/funct into the ALU select code.
- Selects the immediate or register operand, and applies EX/MEM and MEM/WB forwarding.
- Supports stall (hold) and flush (bubble) from the hazard unit.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_ctrl_dec.sv | 34 +++
 rtl/id_ex_alu_feed.sv | 137 +++++++++++++
 tb/tb_id_ex_alu_feed.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings: select codes, aluop values and R-type funct
// fields, imported by the ID/EX feed stage and by the ALU itself.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_RTYPE = 2'b10;
    localparam logic [1:0] AOP_ORI   = 2'b11;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: aluop/funct -> 3-bit ALU select plus a raw
// unsupported-funct flag. Ports: i_aluop, i_funct -> o_sel, o_illegal.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [5:0] i_funct,
    output logic [2:0] o_sel,
    output logic       o_illegal
);

    always_comb begin
        o_sel     = ALU_ADD;
        o_illegal = 1'b0;
        unique case (i_aluop)
            AOP_ADD: o_sel = ALU_ADD;
            AOP_SUB: o_sel = ALU_SUB;
            AOP_ORI: o_sel = ALU_OR;
            AOP_RTYPE: begin
                unique case (i_funct)
                    FN_ADD:  o_sel = ALU_ADD;
                    FN_SUB:  o_sel = ALU_SUB;
                    FN_AND:  o_sel = ALU_AND;
                    FN_OR:   o_sel = ALU_OR;
                    FN_NOR:  o_sel = ALU_NOR;
                    FN_SLT:  o_sel = ALU_SLT;
                    default: o_illegal = 1'b1;
                endcase
            end
            default: o_sel = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/id_ex_alu_feed.sv
// ID/EX stage feeding the ALU: registers decoded fields, picks the
// immediate or register operand, and forwards from EX/MEM and MEM/WB.
// Inputs: clk, rst_n, stall, flush, id_* fields, exm_*/mwb_* writers.
// Outputs: op1, op2, sel, ex_valid, ex_rd, ex_regwrite, illegal.
module id_ex_alu_feed
    import alu_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [1:0]    id_aluop,
    input  logic [5:0]    id_funct,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [15:0]   id_imm,
    input  logic          id_alusrc,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic          id_regwrite,
    input  logic          exm_regwrite,
    input  logic [RW-1:0] exm_rd,
    input  logic [DW-1:0] exm_data,
    input  logic          mwb_regwrite,
    input  logic [RW-1:0] mwb_rd,
    input  logic [DW-1:0] mwb_data,
    output logic [DW-1:0] op1,
    output logic [DW-1:0] op2,
    output logic [2:0]    sel,
    output logic          ex_valid,
    output logic [RW-1:0] ex_rd,
    output logic          ex_regwrite,
    output logic          illegal
);

    logic [2:0]    w_sel;
    logic          w_bad;
    logic [DW-1:0] w_imm_ext;
    logic [DW-1:0] w_fwd_a;
    logic [DW-1:0] w_fwd_b;

    logic          r_valid;
    logic          r_regwrite;
    logic [RW-1:0] r_rd;
    logic [2:0]    r_sel;
    logic          r_illegal;
    logic [RW-1:0] r_rs;
    logic [RW-1:0] r_rt;
    logic [DW-1:0] r_rs_data;
    logic [DW-1:0] r_rt_data;
    logic [DW-1:0] r_imm;
    logic          r_alusrc;

    alu_ctrl_dec u_dec (
        .i_aluop   (id_aluop),
        .i_funct   (id_funct),
        .o_sel     (w_sel),
        .o_illegal (w_bad)
    );

    // ORI zero-extends; every other immediate form sign-extends.
    assign w_imm_ext = (id_aluop == AOP_ORI)
                     ? {{(DW-16){1'b0}}, id_imm}
                     : {{(DW-16){id_imm[15]}}, id_imm};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_sel      <= ALU_ADD;
            r_illegal  <= 1'b0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm      <= '0;
            r_alusrc   <= 1'b0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_sel      <= ALU_ADD;
            r_illegal  <= 1'b0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm      <= '0;
            r_alusrc   <= 1'b0;
        end else if (!stall) begin
            r_valid    <= id_valid;
            // an unsupported funct must never write the register file
            r_regwrite <= id_regwrite & ~w_bad;
            r_rd       <= id_rd;
            r_sel      <= w_sel;
            r_illegal  <= w_bad & id_valid;
            r_rs       <= id_rs;
            r_rt       <= id_rt;
            r_rs_data  <= id_rs_data;
            r_rt_data  <= id_rt_data;
            r_imm      <= w_imm_ext;
            r_alusrc   <= id_alusrc;
        end
    end

    // Younger result (EX/MEM) wins; register 0 is never forwarded.
    always_comb begin
        w_fwd_a = r_rs_data;
        if (exm_regwrite && exm_rd == r_rs && r_rs != '0)
            w_fwd_a = exm_data;
        else if (mwb_regwrite && mwb_rd == r_rs && r_rs != '0)
            w_fwd_a = mwb_data;
    end

    always_comb begin
        w_fwd_b = r_rt_data;
        if (exm_regwrite && exm_rd == r_rt && r_rt != '0)
            w_fwd_b = exm_data;
        else if (mwb_regwrite && mwb_rd == r_rt && r_rt != '0)
            w_fwd_b = mwb_data;
    end

    assign op1         = w_fwd_a;
    assign op2         = r_alusrc ? r_imm : w_fwd_b;
    assign sel         = r_sel;
    assign illegal     = r_illegal;
    assign ex_valid    = r_valid;
    assign ex_rd       = r_rd;
    assign ex_regwrite = r_regwrite & r_valid;

endmodule

// File: tb/tb_id_ex_alu_feed.sv
// Bench for id_ex_alu_feed: directed cases with literal expectations,
// then randomized traffic checked against a behavioural model.
module tb_id_ex_alu_feed;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic        id_valid;
    logic [1:0]  id_aluop;
    logic [5:0]  id_funct;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic        id_alusrc;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_regwrite;
    logic        exm_regwrite;
    logic [4:0]  exm_rd;
    logic [31:0] exm_data;
    logic        mwb_regwrite;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_data;
    logic [31:0] op1, op2;
    logic [2:0]  sel;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        illegal;

    int n_tests = 0;
    int n_fail  = 0;

    // model of the captured instruction
    logic        m_valid, m_rw, m_ill, m_alusrc;
    logic [4:0]  m_rd, m_rs, m_rt;
    logic [2:0]  m_sel;
    logic [31:0] m_rsd, m_rtd, m_immx;

    id_ex_alu_feed dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_aluop(id_aluop),
        .id_funct(id_funct), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alusrc(id_alusrc), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite),
        .exm_regwrite(exm_regwrite), .exm_rd(exm_rd),
        .exm_data(exm_data), .mwb_regwrite(mwb_regwrite),
        .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .op1(op1), .op2(op2), .sel(sel), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {unsupported, sel} straight from the decode table
    function automatic logic [3:0] dec(logic [1:0] a,
                                       logic [5:0] f);
        case (a)
            2'd0: return 4'd0;
            2'd1: return 4'd1;
            2'd3: return 4'd3;
            default: case (f)
                6'h20: return 4'd0;
                6'h22: return 4'd1;
                6'h24: return 4'd2;
                6'h25: return 4'd3;
                6'h27: return 4'd4;
                6'h2A: return 4'd5;
                default: return 4'b1000;
            endcase
        endcase
    endfunction

    function automatic logic [31:0] fwd(logic [4:0] r,
                                        logic [31:0] d);
        if (r == 0) return d;
        if (exm_regwrite && exm_rd == r) return exm_data;
        if (mwb_regwrite && mwb_rd == r) return mwb_data;
        return d;
    endfunction

    task automatic model_clear();
        m_valid = 0; m_rw = 0; m_ill = 0; m_alusrc = 0;
        m_rd = 0; m_rs = 0; m_rt = 0; m_sel = 0;
        m_rsd = 0; m_rtd = 0; m_immx = 0;
    endtask

    task automatic model_clock();
        logic [3:0] d;
        if (!rst_n || flush) begin
            model_clear();
        end else if (!stall) begin
            d = dec(id_aluop, id_funct);
            m_valid  = id_valid;
            m_sel    = d[2:0];
            m_ill    = d[3] & id_valid;
            m_rw     = id_regwrite & ~d[3];
            m_rd     = id_rd;
            m_rs     = id_rs;
            m_rt     = id_rt;
            m_rsd    = id_rs_data;
            m_rtd    = id_rt_data;
            m_alusrc = id_alusrc;
            m_immx   = (id_aluop == 2'd3) ? {16'h0, id_imm}
                     : {{16{id_imm[15]}}, id_imm};
        end
    endtask

    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] e2;
        e2 = m_alusrc ? m_immx : fwd(m_rt, m_rtd);
        chk("op1", op1, fwd(m_rs, m_rsd));
        chk("op2", op2, e2);
        chk("sel", {29'd0, sel}, {29'd0, m_sel});
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
        chk("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
        chk("ex_regwrite", {31'd0, ex_regwrite},
            {31'd0, m_rw & m_valid});
        chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
    endtask

    task automatic cyc();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check_all();
    endtask

    task automatic zero_in();
        stall = 0; flush = 0; id_valid = 0; id_aluop = 0;
        id_funct = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_alusrc = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_regwrite = 0; exm_regwrite = 0; exm_rd = 0;
        exm_data = 0; mwb_regwrite = 0; mwb_rd = 0; mwb_data = 0;
    endtask

    logic [5:0] fn_list [6] = '{6'h20, 6'h22, 6'h24,
                                6'h25, 6'h27, 6'h2A};

    initial begin
        rst_n = 0;
        zero_in();
        model_clear();
        repeat (2) cyc();
        chk("rst ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst sel", {29'd0, sel}, 32'd0);
        @(negedge clk);
        rst_n = 1;

        // 1: R-type AND
        id_valid = 1; id_aluop = 2'b10; id_funct = 6'b100100;
        id_rs_data = 32'hF0F0_0000; id_rt_data = 32'h0FF0_0000;
        id_rs = 1; id_rt = 2; id_rd = 3; id_regwrite = 1;
        cyc();
        chk("t1 sel", {29'd0, sel}, 32'd2);
        chk("t1 op1", op1, 32'hF0F0_0000);
        chk("t1 op2", op2, 32'h0FF0_0000);
        chk("t1 valid", {31'd0, ex_valid}, 32'd1);

        // 2: sign vs zero extension
        id_aluop = 2'b00; id_alusrc = 1; id_imm = 16'hFFFC;
        cyc();
        chk("t2 sext", op2, 32'hFFFF_FFFC);
        id_aluop = 2'b11;
        cyc();
        chk("t2 zext", op2, 32'h0000_FFFC);
        chk("t2 sel", {29'd0, sel}, 32'd3);

        // 3: forwarding priority and register 0
        id_aluop = 0; id_alusrc = 0; id_rs = 5; id_rs_data = 32'hAAAA;
        exm_regwrite = 1; exm_rd = 5; exm_data = 32'h11;
        mwb_regwrite = 1; mwb_rd = 5; mwb_data = 32'h22;
        cyc();
        chk("t3 exm", op1, 32'h11);
        exm_regwrite = 0;
        #1;
        chk("t3 mwb", op1, 32'h22);
        check_all();
        exm_regwrite = 1; exm_rd = 0; mwb_rd = 0;
        id_rs = 0; id_rs_data = 32'h33;
        cyc();
        chk("t3 r0", op1, 32'h33);
        exm_regwrite = 0; mwb_regwrite = 0;

        // 4: stall holds A, flush beats stall
        id_aluop = 2'b10; id_funct = 6'h22; id_rs = 1; id_rt = 2;
        id_rs_data = 32'h100; id_rt_data = 32'h200; id_rd = 7;
        cyc();
        stall = 1;
        id_aluop = 2'b11; id_alusrc = 1; id_imm = 16'h1234;
        id_rs_data = 32'h999; id_rd = 9;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t4 hold sel", {29'd0, sel}, 32'd1);
            chk("t4 hold op1", op1, 32'h100);
            chk("t4 hold op2", op2, 32'h200);
        end
        flush = 1;
        cyc();
        chk("t4 fl valid", {31'd0, ex_valid}, 32'd0);
        chk("t4 fl rw", {31'd0, ex_regwrite}, 32'd0);
        chk("t4 fl sel", {29'd0, sel}, 32'd0);
        stall = 0; flush = 0; id_alusrc = 0;

        // 5: unsupported funct
        id_aluop = 2'b10; id_funct = 6'b000111; id_regwrite = 1;
        cyc();
        chk("t5 ill", {31'd0, illegal}, 32'd1);
        chk("t5 sel", {29'd0, sel}, 32'd0);
        chk("t5 rw", {31'd0, ex_regwrite}, 32'd0);
        id_valid = 0;
        cyc();
        chk("t5 ill nv", {31'd0, illegal}, 32'd0);

        // 6: asynchronous reset between edges
        id_valid = 1; id_funct = 6'h2A;
        cyc();
        chk("t6 pre", {31'd0, ex_valid}, 32'd1);
        #2 rst_n = 0;
        #1;
        chk("t6 valid", {31'd0, ex_valid}, 32'd0);
        chk("t6 sel", {29'd0, sel}, 32'd0);
        model_clear();
        check_all();
        cyc();
        rst_n = 1;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            id_valid = $urandom_range(0, 3) != 0;
            id_aluop = 2'($urandom);
            id_funct = $urandom_range(0, 1) ? fn_list[$urandom_range(0, 5)]
                     : 6'($urandom);
            id_rs_data = $urandom; id_rt_data = $urandom;
            id_imm = 16'($urandom); id_alusrc = 1'($urandom);
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            id_rd = 5'($urandom); id_regwrite = 1'($urandom);
            exm_regwrite = 1'($urandom);
            exm_rd = 5'($urandom_range(0, 3)); exm_data = $urandom;
            mwb_regwrite = 1'($urandom);
            mwb_rd = 5'($urandom_range(0, 3)); mwb_data = $urandom;
            #1;
            check_all();
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
